mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control unit for the ARM-subset core. It decodes the instruction register, sequences fetch, decode, execute, memory and writeback steps, and evaluates condition codes against a private NZCV flag register. It drives every control input of the multicycle datapath: PC/IR/register/memory write enables, the address, source and result mux selects, the immediate format and the ALU operation. It also drives the multiply-mode and FPU-path selects.

## Interface
- FPU_EN, default 1: when 1, Op=11 goes to the FPU states; when 0, Op=11 retires as a NOP.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next clk edge)
- Instr  in  32  instruction register contents
- ALUFlags  in  4  {N,Z,C,V} from the ALU, valid in execute states
- PCWrite  out  1  PC load enable
- MemWrite  out  1  data memory write enable
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register load enable
- AdrSrc  out  1  0=PC, 1=Result as the memory address
- RegSrc  out  2  [0]=read R15 on port 1 (branch); [1]=Rd on port 2 (store)
- ALUSrcA  out  2  00=A register, 01=PC
- ALUSrcB  out  2  00=WriteData register, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=FPUOut
- ImmSrc  out  2  equal to Instr[27:26]
- ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 MUL
- is_mul  out  1  Op=00, I=0 and Instr[7:4]=1001
- State  out  4  current state, for debug

## Operation
- **States:** FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), EXECR(6), EXECI(7), ALUWB(8), BRANCH(9), MULEX(10), FPUEX(11), FPUWB(12). Codes 13–15 are illegal and go to FETCH.
- **FETCH:** AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1. Next state DECODE.
- **DECODE:** ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10 (PC+8 placed on the R15 read). At the end of this state, condex_q latches CondEx(Instr[31:28], Flags).
- **Next state after DECODE:**
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=00 with I=1 → EXECI.
  - Op=00 with is_mul → MULEX.
  - Op=00 otherwise → EXECR.
  - Op=11 → FPUEX if FPU_EN, else FETCH.
- **MEMADR:** ALUSrcA=00, ALUSrcB=01, ADD. Next state MEMRD if L=Instr[20] is 1, else MEMWR.
- **MEMRD:** AdrSrc=1, ResultSrc=00. Next state MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=condex_q. Next state FETCH.
- **MEMWR:** AdrSrc=1, ResultSrc=00, MemWrite=condex_q. Next state FETCH.
- **EXECR / EXECI:** ALUSrcA=00; ALUSrcB=00 (EXECR) or 01 (EXECI). ALUControl is decoded from Instr[24:21]:
  - 0100 → ADD; 0010 → SUB; 0000 → AND; 1100 → ORR; 1010 (CMP) → SUB.
  - Any other opcode → ADD.
  - Next state ALUWB.
- **MULEX:** ALUSrcA=00, ALUSrcB=00, ALUControl=MUL, is_mul=1. Next state ALUWB.
- **FPUEX:** ALUSrcA=00, ALUSrcB=00 (FPU op is taken from Instr[22:21]). Next state FPUWB.
- **FPUWB:** ResultSrc=11, RegWrite=condex_q. Next state FETCH.
- **ALUWB:** ResultSrc=00, RegWrite=condex_q & ~CMP. Next state FETCH.
- **BRANCH:** ALUSrcA=00, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=condex_q. Next state FETCH.
- **Flags:** in EXECR, EXECI and MULEX, if S=Instr[20] and condex_q, Flags ← ALUFlags at the clock edge. CMP always has S set. MUL updates N and Z only.
- **CondEx:** standard ARM table over the 15 condition codes (EQ…AL); 1111 evaluates to 0.
- **Decode-derived outputs:** RegSrc, ImmSrc and is_mul are combinational from Instr in every state.
- **Moore outputs:** all state outputs are functions of state (plus condex_q). Signals not listed for a state are 0.

## Timing
- **Reset:** while reset==0 at a clk edge, state←FETCH, Flags←0000 and condex_q←0. PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 combinationally while reset==0, so there are no writes during reset. The first fetch occurs in the cycle after reset is released.
- **Reset mid-instruction:** abandons the instruction immediately. No pending write is issued.
- **Latency per instruction class:**
  - Data-processing, MUL, FPU: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - FPU_EN=0 with Op=11: 2 cycles.
- **Flag timing:** a flag update becomes visible to the next instruction's DECODE. The current instruction's writeback uses condex_q, which is unaffected by its own flag update.
- **Failed condition:** state sequencing is unchanged; only the enables are suppressed.

## Test plan
- ADD R2,R0,R1 (0xE0802001) → states 0,1,6,8,0; ALUControl=0000 in state 6; RegWrite=1 only in state 8; PCWrite=1 only in state 0.
- LDR R3,[R0,#4] (0xE5903004) → states 0,1,2,3,4; ALUSrcB=01 in state 2; AdrSrc=1 in state 3; ResultSrc=01 and RegWrite=1 in state 4.
- SUBS R0,R0,#1 (0xE2500001) with ALUFlags=0100, then STREQ R3,[R0] (0x05803000) → Flags=0100; STREQ reaches MEMWR with MemWrite=1. Repeat with ALUFlags=0000 → MemWrite=0 and the sequence is unchanged.
- B +8 (0xEA000002) → states 0,1,9; RegSrc[0]=1; PCWrite=1 in state 9. BNE (0x1A000002) with Z=1 → PCWrite=0 in state 9.
- MUL R4,R1,R2 (0xE0040291) → is_mul=1; states 0,1,10,8; ALUControl=0100. FPU op (0xEE000001): FPU_EN=1 → states 11,12 with ResultSrc=11; FPU_EN=0 → DECODE→FETCH with no writes.
- reset=0 asserted during MEMWR of a store → MemWrite=0 that cycle; next state is FETCH; Flags=0000; no write enable is high until reset=1.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control unit for the ARM-subset core.
// Decodes the instruction register, sequences the fetch / decode / execute /
// memory / writeback steps, keeps a private NZCV flag register and evaluates
// condition codes against it. All datapath control inputs are driven from here.
module mc_control_fsm #(
    parameter bit FPU_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        is_mul,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_MULEX  = 4'd10,
        S_FPUEX  = 4'd11,
        S_FPUWB  = 4'd12
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0100;

    // ARM condition-code evaluation over {N,Z,C,V}; code 1111 never executes.
    function automatic logic condex_f(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: res = z;                    // EQ
            4'b0001: res = ~z;                   // NE
            4'b0010: res = c;                    // CS
            4'b0011: res = ~c;                   // CC
            4'b0100: res = n;                    // MI
            4'b0101: res = ~n;                   // PL
            4'b0110: res = v;                    // VS
            4'b0111: res = ~v;                   // VC
            4'b1000: res = c & ~z;               // HI
            4'b1001: res = ~c | z;               // LS
            4'b1010: res = ~(n ^ v);             // GE
            4'b1011: res = n ^ v;                // LT
            4'b1100: res = ~z & ~(n ^ v);        // GT
            4'b1101: res = z | (n ^ v);          // LE
            4'b1110: res = 1'b1;                 // AL
            default: res = 1'b0;                 // 1111: never
        endcase
        return res;
    endfunction

    // Data-processing opcode to ALU operation; CMP shares the subtractor.
    function automatic logic [3:0] alu_dec_f(input logic [3:0] cmd);
        logic [3:0] op;
        case (cmd)
            4'b0100: op = ALU_ADD;
            4'b0010: op = ALU_SUB;
            4'b0000: op = ALU_AND;
            4'b1100: op = ALU_ORR;
            4'b1010: op = ALU_SUB;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic        condex_q, condex_d;

    // Instruction fields
    logic [3:0]  cond_s;
    logic [1:0]  op_s;
    logic        imm_s;
    logic [3:0]  cmd_s;
    logic        sbit_s;
    logic        is_mul_s;
    logic        is_cmp_s;

    // Raw enables before the reset gate
    logic        pc_write_s, mem_write_s, reg_write_s, ir_write_s;

    // Fields that only the datapath consumes (register numbers, immediates)
    logic        unused_instr_s;

    assign cond_s   = Instr[31:28];
    assign op_s     = Instr[27:26];
    assign imm_s    = Instr[25];
    assign cmd_s    = Instr[24:21];
    assign sbit_s   = Instr[20];
    assign is_mul_s = (op_s == 2'b00) && !imm_s && (Instr[7:4] == 4'b1001);
    assign is_cmp_s = (cmd_s == 4'b1010);
    assign unused_instr_s = ^{Instr[19:8], Instr[3:0]};

    // Decode-derived outputs follow the instruction register in every state;
    // RegSrc[1] routes Rd to read port 2 only for stores, where it is the data.
    assign RegSrc = {(op_s == 2'b01) && !sbit_s, (op_s == 2'b10)};
    assign ImmSrc = op_s;
    assign is_mul = is_mul_s;
    assign State  = state_q;

    // Write enables are held low while reset is asserted so nothing commits.
    assign PCWrite  = pc_write_s  & reset;
    assign MemWrite = mem_write_s & reset;
    assign RegWrite = reg_write_s & reset;
    assign IRWrite  = ir_write_s  & reset;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Flag register and latched condition result, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    // Next-state sequencing per instruction class.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op_s)
                    2'b01: state_d = S_MEMADR;
                    2'b10: state_d = S_BRANCH;
                    2'b00: begin
                        if (imm_s) begin
                            state_d = S_EXECI;
                        end else if (is_mul_s) begin
                            state_d = S_MULEX;
                        end else begin
                            state_d = S_EXECR;
                        end
                    end
                    2'b11: begin
                        if (FPU_EN) begin
                            state_d = S_FPUEX;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (sbit_s) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_MULEX:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_FPUEX:  state_d = S_FPUWB;
            S_FPUWB:  state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Condition latch at the end of DECODE and conditional flag update in execute;
    // MUL only produces meaningful N and Z, so C and V are kept.
    always_comb begin
        condex_d = condex_q;
        flags_d  = flags_q;
        if (state_q == S_DECODE) begin
            condex_d = condex_f(cond_s, flags_q);
        end else begin
            condex_d = condex_q;
        end
        if (((state_q == S_EXECR) || (state_q == S_EXECI)) && sbit_s && condex_q) begin
            flags_d = ALUFlags;
        end else if ((state_q == S_MULEX) && sbit_s && condex_q) begin
            flags_d = {ALUFlags[3:2], flags_q[1:0]};
        end else begin
            flags_d = flags_q;
        end
    end

    // Moore control outputs per state; anything not named for a state is 0.
    always_comb begin
        pc_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        ir_write_s  = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALUControl  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_DECODE: begin
                // PC+8 is formed here and appears on the R15 read
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b00;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
            end
            S_MEMRD: begin
                AdrSrc    = 1'b1;
                ResultSrc = 2'b00;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = condex_q;
            end
            S_MEMWR: begin
                AdrSrc      = 1'b1;
                ResultSrc   = 2'b00;
                mem_write_s = condex_q;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b00;
                ALUSrcB    = 2'b00;
                ALUControl = alu_dec_f(cmd_s);
            end
            S_EXECI: begin
                ALUSrcA    = 2'b00;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec_f(cmd_s);
            end
            S_MULEX: begin
                ALUSrcA    = 2'b00;
                ALUSrcB    = 2'b00;
                ALUControl = ALU_MUL;
            end
            S_ALUWB: begin
                ResultSrc   = 2'b00;
                reg_write_s = condex_q & ~is_cmp_s;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b00;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b10;
                pc_write_s = condex_q;
            end
            S_FPUEX: begin
                // FPU operation select comes straight from Instr[22:21]
                ALUSrcA = 2'b00;
                ALUSrcB = 2'b00;
            end
            S_FPUWB: begin
                ResultSrc   = 2'b11;
                reg_write_s = condex_q;
            end
            default: begin
                pc_write_s  = 1'b0;
                mem_write_s = 1'b0;
                reg_write_s = 1'b0;
                ir_write_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed instruction sequences
// followed by randomized instructions, checked against an instruction-level
// reference model that lists the expected step sequence for each class.
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, is_mul;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [3:0]  ALUControl, State;

    logic        n_reset;
    logic [31:0] n_instr;
    logic [3:0]  n_aluflags;
    logic        n_PCWrite, n_MemWrite, n_RegWrite, n_IRWrite, n_AdrSrc, n_is_mul;
    logic [1:0]  n_RegSrc, n_ALUSrcA, n_ALUSrcB, n_ResultSrc, n_ImmSrc;
    logic [3:0]  n_ALUControl, n_State;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] flags_m;

    always #5 clk = ~clk;

    mc_control_fsm u_dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .is_mul(is_mul), .State(State)
    );

    mc_control_fsm #(.FPU_EN(1'b0)) u_dut_nofpu (
        .clk(clk), .reset(n_reset), .Instr(n_instr), .ALUFlags(n_aluflags),
        .PCWrite(n_PCWrite), .MemWrite(n_MemWrite), .RegWrite(n_RegWrite), .IRWrite(n_IRWrite),
        .AdrSrc(n_AdrSrc), .RegSrc(n_RegSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
        .ResultSrc(n_ResultSrc), .ImmSrc(n_ImmSrc), .ALUControl(n_ALUControl),
        .is_mul(n_is_mul), .State(n_State)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, mw, rw, irw, adr;
        logic [1:0] asa, asb, rs;
        logic [3:0] aluc;
    } exp_t;

    wire [23:0] obs_main = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                            ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, is_mul};
    wire [23:0] obs_nofpu = {n_State, n_PCWrite, n_MemWrite, n_RegWrite, n_IRWrite, n_AdrSrc,
                             n_RegSrc, n_ALUSrcA, n_ALUSrcB, n_ResultSrc, n_ImmSrc,
                             n_ALUControl, n_is_mul};

    function automatic exp_t mk(input logic [3:0] st, input logic pcw, input logic mw,
                                input logic rw, input logic irw, input logic adr,
                                input logic [1:0] asa, input logic [1:0] asb,
                                input logic [1:0] rs, input logic [3:0] aluc);
        exp_t e;
        e.st = st; e.pcw = pcw; e.mw = mw; e.rw = rw; e.irw = irw; e.adr = adr;
        e.asa = asa; e.asb = asb; e.rs = rs; e.aluc = aluc;
        return e;
    endfunction

    // Full expected output word: step controls plus instruction-derived fields
    function automatic logic [23:0] pack_exp(input exp_t e, input logic [31:0] ins, input logic rst);
        logic [1:0] op;
        logic       st_mem, br, mul;
        op     = ins[27:26];
        st_mem = (op == 2'b01) && !ins[20];
        br     = (op == 2'b10);
        mul    = (op == 2'b00) && !ins[25] && (ins[7:4] == 4'b1001);
        return {e.st, e.pcw & rst, e.mw & rst, e.rw & rst, e.irw & rst, e.adr, st_mem, br,
                e.asa, e.asb, e.rs, op, e.aluc, mul};
    endfunction

    // ARM condition table by mnemonic
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 4'b0000;
            4'b0010: return 4'b0001;
            4'b0000: return 4'b0010;
            4'b1100: return 4'b0011;
            4'b1010: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus: drive, settle, compare, advance past the edge
    task automatic do_step(input exp_t e, input logic [31:0] ins, input logic rst, input logic [3:0] af);
        Instr    = ins;
        ALUFlags = af;
        reset    = rst;
        #2;
        chk($sformatf("st%0d_i%08h_r%0d", e.st, ins, rst), obs_main, pack_exp(e, ins, rst));
        @(posedge clk);
        #1;
    endtask

    // Execute one instruction against the model; abort_at >= 0 pulls reset low at that step
    task automatic run_instr(input logic [31:0] ins, input bit fix_af, input logic [3:0] af_val,
                             input int abort_at);
        exp_t        steps[$];
        logic [1:0]  op;
        logic        pass, cmp, sflag, mulop;
        logic [3:0]  cmd, af;
        int          exec_idx;
        op       = ins[27:26];
        cmd      = ins[24:21];
        sflag    = ins[20];
        cmp      = (cmd == 4'b1010);
        mulop    = (op == 2'b00) && !ins[25] && (ins[7:4] == 4'b1001);
        pass     = cond_ok(ins[31:28], flags_m);
        exec_idx = -1;
        steps.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 4'b0000));
        steps.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 4'b0000));
        case (op)
            2'b01: begin
                steps.push_back(mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 4'b0000));
                if (sflag) begin
                    steps.push_back(mk(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000));
                    steps.push_back(mk(4'd4, 1'b0, 1'b0, pass, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 4'b0000));
                end else begin
                    steps.push_back(mk(4'd5, 1'b0, pass, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000));
                end
            end
            2'b10: steps.push_back(mk(4'd9, pass, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 4'b0000));
            2'b00: begin
                exec_idx = 2;
                if (ins[25])
                    steps.push_back(mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, alu_of(cmd)));
                else if (mulop)
                    steps.push_back(mk(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0100));
                else
                    steps.push_back(mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, alu_of(cmd)));
                steps.push_back(mk(4'd8, 1'b0, 1'b0, pass && !cmp, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000));
            end
            default: begin
                steps.push_back(mk(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000));
                steps.push_back(mk(4'd12, 1'b0, 1'b0, pass, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 4'b0000));
            end
        endcase
        for (int i = 0; i < steps.size(); i++) begin
            af = fix_af ? af_val : 4'($urandom);
            if (i == abort_at) begin
                do_step(steps[i], ins, 1'b0, af);
                // still in reset: back in FETCH with every enable low
                do_step(mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 4'b0000),
                        ins, 1'b0, af);
                flags_m = 4'b0000;
                return;
            end
            do_step(steps[i], ins, 1'b1, af);
            if (i == exec_idx && sflag && pass)
                flags_m = mulop ? {af[3:2], flags_m[1:0]} : af;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        exp_t        rst_fetch, f_e, d_e;
        rst_fetch = mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 4'b0000);
        f_e       = rst_fetch;
        d_e       = mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 4'b0000);
        reset      = 1'b0;
        n_reset    = 1'b0;
        Instr      = 32'h0000_0000;
        ALUFlags   = 4'b0000;
        n_instr    = 32'hEE00_0001;
        n_aluflags = 4'b0000;
        flags_m    = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Main instance held in reset; FPU-less instance runs an FPU op as a NOP
        for (int k = 0; k < 6; k++) begin
            n_reset = 1'b1;
            #2;
            chk("reset_state", obs_main, pack_exp(rst_fetch, 32'h0000_0000, 1'b0));
            chk($sformatf("nofpu_cyc%0d", k), obs_nofpu,
                pack_exp((k % 2 == 0) ? f_e : d_e, 32'hEE00_0001, 1'b1));
            @(posedge clk); #1;
        end

        // Directed instruction sequences
        run_instr(32'hE080_2001, 1'b0, 4'b0000, -1);   // ADD R2,R0,R1
        run_instr(32'hE590_3004, 1'b0, 4'b0000, -1);   // LDR R3,[R0,#4]
        run_instr(32'hE250_0001, 1'b1, 4'b0100, -1);   // SUBS -> Z set
        run_instr(32'h0580_3000, 1'b0, 4'b0000, -1);   // STREQ, writes
        run_instr(32'hEA00_0002, 1'b0, 4'b0000, -1);   // B
        run_instr(32'h1A00_0002, 1'b0, 4'b0000, -1);   // BNE, not taken
        run_instr(32'hE250_0001, 1'b1, 4'b0000, -1);   // SUBS -> Z clear
        run_instr(32'h0580_3000, 1'b0, 4'b0000, -1);   // STREQ, suppressed
        run_instr(32'hE004_0291, 1'b0, 4'b0000, -1);   // MUL R4,R1,R2
        run_instr(32'hEE00_0001, 1'b0, 4'b0000, -1);   // FPU op
        run_instr(32'hE250_0001, 1'b1, 4'b0100, -1);   // SUBS -> Z set
        run_instr(32'hE580_3000, 1'b0, 4'b0000, 3);    // STR, reset during MEMWR
        run_instr(32'h0A00_0002, 1'b0, 4'b0000, -1);   // BEQ after reset: flags cleared
        run_instr(32'hE350_0000, 1'b1, 4'b0110, -1);   // CMP: flags only
        run_instr(32'hE010_0291, 1'b1, 4'b1111, -1);   // MULS: N,Z only
        run_instr(32'h2A00_0002, 1'b0, 4'b0000, -1);   // BCS: C kept from CMP
        run_instr(32'hFA00_0002, 1'b0, 4'b0000, -1);   // cond 1111 never

        // Randomized instructions
        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                ins[27:25] = 3'b000;
                ins[7:4]   = 4'b1001;
            end
            if ($urandom_range(0, 2) == 0)
                ins[31:28] = 4'hE;
            run_instr(ins, 1'b0, 4'b0000, ($urandom_range(0, 29) == 0) ? 2 : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
